// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-Stream style FIFO: width calculation for
// pointers and the occupancy counter.
package axis_fifo_pkg;

  // Ceiling log2, never less than 1 so a width derived from it is always legal.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. The asynchronous read lets the head word be visible on the cycle right
// after it is written, which first-word-fall-through needs.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// Ready/valid FIFO with first-word-fall-through output. Both handshake flags
// are registered and derived from the next occupancy, so neither input_ready
// nor output_valid has a combinational path from the opposite side.
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [DATA_WIDTH-1:0] output_data
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             output_valid_q, output_valid_d;
  logic             input_ready_q, input_ready_d;
  logic             push, pop;

  // Pointers wrap at FIFO_DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes use only registered flags; nothing moves on a reset edge.
  assign push = input_valid & input_ready_q & ~rst;
  assign pop  = output_valid_q & output_ready & ~rst;

  // Next pointers, occupancy and the flags that follow from it.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    output_valid_d = output_valid_q;
    input_ready_d  = input_ready_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    output_valid_d = (count_d != '0);
    input_ready_d  = (count_d < FULL_CNT);
  end

  // State register; reset holds input_ready low until the first free edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      output_valid_q <= 1'b0;
      input_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      output_valid_q <= output_valid_d;
      input_ready_q  <= input_ready_d;
    end
  end

  axis_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .ADDR_W    (PTR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data(input_data),
    .rd_addr(rd_ptr_q),
    .rd_data(output_data)
  );

  assign input_ready  = input_ready_q;
  assign output_valid = output_valid_q;

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of an ordered buffer with FIFO_DEPTH slots.
module tb_axis_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          input_valid = 1'b0;
  logic          input_ready;
  logic [DW-1:0] input_data = '0;
  logic          output_valid;
  logic          output_ready = 1'b0;
  logic [DW-1:0] output_data;

  int total = 0;
  int bad   = 0;

  // Reference model: stored words in arrival order, plus whether the FIFO
  // has seen a non-reset edge since the last reset (input_ready gate).
  logic [DW-1:0] model_q[$];
  bit            rdy_en = 1'b0;
  logic [DW-1:0] d_ctr  = '0;

  axis_fifo #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_data (output_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, update model at edge.
  task automatic step(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
    bit exp_valid;
    bit exp_ready;
    bit do_push;
    bit do_pop;
    rst          = r;
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
    @(negedge clk);
    exp_valid = (model_q.size() > 0);
    exp_ready = rdy_en && (model_q.size() < DEPTH);
    check("output_valid", 64'(output_valid), 64'(exp_valid));
    check("input_ready", 64'(input_ready), 64'(exp_ready));
    if (exp_valid) begin
      check("output_data", 64'(output_data), 64'(model_q[0]));
    end
    do_push = !r && iv && exp_ready;
    do_pop  = !r && ordy && exp_valid;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      rdy_en = 1'b0;
      $display("t=%0t reset", $time);
    end else begin
      if (do_pop) begin
        $display("t=%0t pop  data=%h", $time, model_q[0]);
        void'(model_q.pop_front());
      end
      if (do_push) begin
        model_q.push_back(d);
        $display("t=%0t push data=%h level=%0d", $time, d, model_q.size());
      end
      rdy_en = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [DW-1:0] dx;
    int            n;

    // Reset for two edges, then release.
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Fill with an incrementing pattern while downstream stalls.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, d_ctr, 1'b0);
      d_ctr++;
    end
    check("fill_level", 64'(model_q.size()), 64'(DEPTH));
    check("fill_head", 64'(output_data), 64'(0));

    // Drain while upstream keeps offering words.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, d_ctr, 1'b1);
      d_ctr++;
    end

    // Drain to empty, bounded.
    n = 0;
    while (model_q.size() > 0 && n < 40) begin
      step(1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    @(negedge clk);
    check("drained_valid", 64'(output_valid), 64'(0));
    check("drained_ready", 64'(input_ready), 64'(1));
    @(posedge clk);
    #1;

    // Pass-through: continuous push and pop from empty.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, d_ctr, 1'b1);
      d_ctr++;
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Mid-operation reset with five words stored.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, d_ctr, 1'b0);
      d_ctr++;
    end
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    dx = 32'h0BAD_F00D;
    step(1'b0, 1'b1, dx, 1'b0);
    step(1'b0, 1'b1, dx, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("midrst_first", 64'(output_data), 64'(dx));
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic: first half biased to fill, second half to drain.
    for (int i = 0; i < 500; i++) begin
      logic r;
      logic iv;
      logic ordy;
      r    = ($urandom_range(0, 199) == 0);
      iv   = (i < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ordy = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(r, iv, DW'($urandom), ordy);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bit width of each data word.
REQ-002 Parameter FIFO_DEPTH, default 16, number of storable words; any integer >= 2, power of two not required.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 input_valid  in  1  upstream word present on input_data.
REQ-006 input_ready  out  1  FIFO can accept a word this cycle.
REQ-007 input_data  in  DATA_WIDTH  upstream word.
REQ-008 output_valid  out  1  word present on output_data.
REQ-009 output_ready  in  1  downstream accepts the word this cycle.
REQ-010 output_data  out  DATA_WIDTH  oldest stored word.

Function
REQ-011 Push SHALL occur on a rising edge where input_valid=1 and input_ready=1; pop SHALL occur on a rising edge where output_valid=1 and output_ready=1.
REQ-012 Words SHALL leave in exactly the order accepted, unmodified, with no loss or duplication.
REQ-013 Occupancy count SHALL range 0..FIFO_DEPTH, width clog2(FIFO_DEPTH+1): +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-014 input_ready SHALL be 1 iff count < FIFO_DEPTH, registered, with no combinational path from output_ready or input_valid.
REQ-015 output_valid SHALL be 1 iff count > 0, registered, with no combinational path from input_valid or output_ready.
REQ-016 output_data SHALL always present the oldest stored word (first-word-fall-through); its value is don't-care while output_valid=0.
REQ-017 Latency: a word pushed into an empty FIFO at edge N SHALL appear with output_valid=1 after edge N, i.e. available for pop at edge N+1.
REQ-018 Full (count=FIFO_DEPTH): input_ready=0, so no push occurs even when a pop occurs on the same edge; input_ready returns to 1 after the first pop.
REQ-019 Empty (count=0): output_valid=0, so no pop occurs; a simultaneous push SHALL make output_valid 1 after that edge.
REQ-020 Simultaneous push and pop when 0 < count < FIFO_DEPTH SHALL keep count constant and advance both pointers.
REQ-021 Read and write pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-022 output_valid and output_data SHALL hold stable while output_valid=1 and output_ready=0.
REQ-023 input_data is ignored whenever input_valid=0 or input_ready=0.

Reset
REQ-024 While rst=1 at a rising edge: count, read pointer and write pointer SHALL clear to 0, output_valid=0 and input_ready=0; storage contents are not cleared.
REQ-025 At the first rising edge with rst=0, input_ready SHALL become 1; no push SHALL be accepted on any edge where rst=1.
REQ-026 Reset asserted mid-operation SHALL discard all stored words and give the same state as a reset from power-up.

Structure
REQ-027 Storage SHALL be an array of FIFO_DEPTH words of DATA_WIDTH, inferable as distributed or block RAM.
REQ-028 A shared package SHALL provide a clog2 helper function for pointer and count widths; no typedefs are required.
REQ-029 A single sub-module is natural: axis_fifo_ram, a simple dual-port RAM (one write port, one read port); the control logic stays in axis_fifo.

Verification
REQ-030 Reset then idle: rst high for 2 cycles -> output_valid=0 throughout; input_ready=0 during reset and 1 on the first edge after release.
REQ-031 Fill: input_valid=1 with data incrementing by 1 per cycle (D0..), output_ready=0 for 32 cycles -> exactly 16 words (D0..D15) accepted; input_ready=0 from the edge accepting D15 onward; output_valid=1 with output_data=D0 held.
REQ-032 Drain while full: output_ready=1, input_valid=1 for 16 cycles -> outputs D0, D1, ... in order; input_ready toggles with no push on a full edge; count never exceeds 16.
REQ-033 Drain to empty: input_valid=0, output_ready=1 -> all remaining words emitted in order, then output_valid=0 and input_ready=1.
REQ-034 Pass-through: empty FIFO, input_valid=1 and output_ready=1 continuously -> each word appears one cycle after acceptance; count alternates 0/1 or stays 1, never grows.
REQ-035 Mid-operation reset: with 5 words stored, assert rst for 1 cycle -> output_valid=0 and count=0; the next pushed word Dx is the first one output.
